pipe_chain: RTL and testbench

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_chain.sv | 94 +++++++++
 tb/tb_pipe_chain.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_chain.sv
// pipe_chain: elastic linear pipeline of STAGES valid/data registers.
// Items advance toward the output whenever the stage ahead is free or will be
// freed this cycle. Empty stages collapse, so a stalled sink still lets
// younger items close up behind the oldest one. A global stall freezes
// everything. A per-stage flush mask invalidates selected stages and blocks all
// movement in that cycle.
module pipe_chain #(
  parameter  int DATA_W = 32,
  parameter  int STAGES = 4,
  localparam int CNT_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall,
  input  logic [STAGES-1:0] flush_mask,
  output logic [CNT_W-1:0]  occupancy
);

  logic [STAGES-1:0]             v_q, v_d;
  logic [STAGES-1:0][DATA_W-1:0] d_q, d_d;
  logic [CNT_W-1:0]              occ_q, occ_d;
  logic [STAGES-1:0]             rdy;
  logic                          flush_any;
  logic                          move_en;
  logic                          in_fire;

  assign flush_any = |flush_mask;
  assign move_en   = !stall && !flush_any;

  // Stage k can take an item when some stage from k to the output is empty
  // or the sink is ready. This is the unrolled form of the chain
  // rdy[k] = !v[k] || rdy[k+1]. Unrolling avoids a bit-to-bit combinational
  // path inside one vector.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_rdy
    assign rdy[gi] = out_ready || !(&v_q[STAGES-1:gi]);
  end

  assign in_ready  = rdy[0] && move_en;
  assign out_valid = v_q[STAGES-1] && move_en;
  assign out_data  = d_q[STAGES-1];
  assign occupancy = occ_q;
  assign in_fire   = in_valid && in_ready;

  // Next valid/data state: flush beats stall, and stall beats movement.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush_any) begin
      v_d = v_q & ~flush_mask;
    end else if (!stall) begin
      for (int k = 1; k < STAGES; k++) begin
        // A valid item leaves stage k exactly when rdy[k] is high.
        // The item behind it moves up under the same condition.
        v_d[k] = (v_q[k] && !rdy[k]) || (v_q[k-1] && rdy[k]);
        if (v_q[k-1] && rdy[k]) begin
          d_d[k] = d_q[k-1];
        end
      end
      v_d[0] = (v_q[0] && !rdy[0]) || in_fire;
      if (in_fire) begin
        d_d[0] = in_data;
      end
    end
  end

  // Occupancy is registered as the population count of the next valid vector.
  // It therefore always matches the valid bits currently held.
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ_d = occ_d + CNT_W'(v_d[k]);
    end
  end

  // State registers: asynchronous reset empties the pipe and clears payloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      d_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: scoreboard bench for pipe_chain (DATA_W=32, STAGES=4).
// The reference model is an ordered list of in-flight items, oldest first.
// Each item carries its stage position. Every cycle, each item steps one
// position toward the output if the slot ahead is free after older items have
// moved. The oldest item leaves the last stage when the sink is ready.
module tb_pipe_chain;

  localparam int DW = 32;
  localparam int ST = 4;
  localparam int CW = $clog2(ST + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          stall = 1'b0;
  logic [ST-1:0] flush_mask = '0;
  logic [CW-1:0] occupancy;

  pipe_chain #(.DATA_W(DW), .STAGES(ST)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .stall      (stall),
    .flush_mask (flush_mask),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            pos;
  } item_t;

  item_t         model[$];
  item_t         tmp[$];
  logic [DW-1:0] delivered[$];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples between edges, checks against the model, then advances the model.
  int    m_n;
  int    free_at;
  bit    m_last, m_fl, m_ev, m_er;
  item_t it;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        model.delete();
      end else begin
        m_n    = model.size();
        m_last = (m_n > 0) && (model[0].pos == ST - 1);
        m_fl   = (flush_mask != 0);
        m_ev   = m_last && !stall && !m_fl;
        m_er   = (out_ready || (m_n < ST)) && !stall && !m_fl;
        check("occupancy", 64'(occupancy), 64'(m_n));
        check("out_valid", 64'(out_valid), 64'(m_ev));
        check("in_ready", 64'(in_ready), 64'(m_er));
        if (m_ev && out_ready) begin
          check("out_data", 64'(out_data), 64'(model[0].data));
          delivered.push_back(out_data);
        end
        if (m_fl) begin
          tmp.delete();
          foreach (model[i]) if (!flush_mask[model[i].pos]) tmp.push_back(model[i]);
          model = tmp;
        end else if (!stall) begin
          tmp.delete();
          free_at = ST;
          foreach (model[i]) begin
            it = model[i];
            if (it.pos == ST - 1) begin
              if (!out_ready) begin
                free_at = it.pos;
                tmp.push_back(it);
              end
            end else begin
              if (it.pos + 1 < free_at) it.pos++;
              free_at = it.pos;
              tmp.push_back(it);
            end
          end
          if (in_valid && m_er) begin
            it.data = in_data;
            it.pos  = 0;
            tmp.push_back(it);
          end
          model = tmp;
        end
      end
    end
  end

  task automatic drive(input bit iv, input logic [DW-1:0] id, input bit ordy,
                       input bit st, input logic [ST-1:0] fm);
    @(negedge clk);
    in_valid   = iv;
    in_data    = id;
    out_ready  = ordy;
    stall      = st;
    flush_mask = fm;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) drive(1'b0, '0, ordy, 1'b0, '0);
  endtask

  int idx;
  logic [ST-1:0] fm;

  initial begin
    // Reset: asynchronous assertion clears outputs before any clock edge.
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);

    // Streaming: three items back to back with the sink ready.
    delivered.delete();
    drive(1'b1, 32'h11, 1'b1, 1'b0, '0);
    drive(1'b1, 32'h22, 1'b1, 1'b0, '0);
    drive(1'b1, 32'h33, 1'b1, 1'b0, '0);
    idle(1, 1'b1);
    #1 check("stream_not_yet", 64'(out_valid), 64'd0);
    idle(1, 1'b1);
    #1 check("stream_first", 64'({out_valid, out_data}), 64'({1'b1, 32'h11}));
    idle(1, 1'b1);
    #1 check("stream_second", 64'({out_valid, out_data}), 64'({1'b1, 32'h22}));
    idle(1, 1'b1);
    #1 check("stream_third", 64'({out_valid, out_data}), 64'({1'b1, 32'h33}));
    idle(4, 1'b1);
    check("stream_count", 64'(delivered.size()), 64'd3);

    // Backpressure: five offers into a blocked sink; only four fit.
    delivered.delete();
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 32'hA0 + idx, 1'b0, 1'b0, '0);
      #1 if (in_ready) idx++;
    end
    check("bp_accepted", 64'(idx), 64'd4);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_occupancy", 64'(occupancy), 64'd4);
    for (int c = 0; c < 10; c++) begin
      drive(idx < 5, 32'hA0 + idx, 1'b1, 1'b0, '0);
      #1 if (in_valid && in_ready) idx++;
    end
    idle(6, 1'b1);
    check("bp_delivered", 64'(delivered.size()), 64'd5);
    for (int i = 0; i < 5 && i < delivered.size(); i++)
      check("bp_order", 64'(delivered[i]), 64'(32'hA0 + i));

    // Bubble collapse: second item closes up to stage 2 behind a blocked head.
    drive(1'b1, 32'hB1, 1'b0, 1'b0, '0);
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    drive(1'b1, 32'hB2, 1'b0, 1'b0, '0);
    idle(3, 1'b0);
    idle(1, 1'b0);
    check("bubble_occupancy", 64'(occupancy), 64'd2);
    out_ready = 1'b1;
    #1 check("bubble_head", 64'(out_data), 64'hB1);
    idle(1, 1'b0);
    #1 check("bubble_next", 64'({out_valid, out_data}), 64'({1'b1, 32'hB2}));
    idle(6, 1'b1);

    // Flush beats stall: drop the two youngest of a full pipe.
    delivered.delete();
    drive(1'b1, 32'hC0, 1'b0, 1'b0, '0);
    drive(1'b1, 32'hC1, 1'b0, 1'b0, '0);
    drive(1'b1, 32'hC2, 1'b0, 1'b0, '0);
    drive(1'b1, 32'hC3, 1'b0, 1'b0, '0);
    drive(1'b1, 32'hEE, 1'b1, 1'b1, 4'b0011);
    #1 check("flush_in_ready", 64'(in_ready), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    check("flush_occupancy", 64'(occupancy), 64'd2);
    idle(8, 1'b1);
    check("flush_delivered", 64'(delivered.size()), 64'd2);
    if (delivered.size() >= 2) begin
      check("flush_first", 64'(delivered[0]), 64'hC0);
      check("flush_second", 64'(delivered[1]), 64'hC1);
    end

    // Mid-operation reset discards in-flight items immediately.
    drive(1'b1, 32'hD0, 1'b0, 1'b0, '0);
    drive(1'b1, 32'hD1, 1'b0, 1'b0, '0);
    drive(1'b1, 32'hD2, 1'b0, 1'b0, '0);
    idle(1, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_occupancy", 64'(occupancy), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    delivered.delete();
    idle(8, 1'b1);
    check("midrst_none_back", 64'(delivered.size()), 64'd0);

    // Random traffic with stalls and flushes, checked by the monitor.
    for (int c = 0; c < 3000; c++) begin
      fm = ($urandom_range(0, 19) == 0) ? ST'($urandom_range(1, 15)) : '0;
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
            $urandom_range(0, 9) == 0, fm);
    end
    idle(10, 1'b1);
    check("final_empty", 64'(occupancy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
